// File: rtl/vram_bus_reader.sv
// vram_bus_reader: shares the video RAM read port between display fetch and CPU read-back
`timescale 1ns/1ps
module vram_bus_reader #(
  parameter int          CELL_W = 16,
  parameter logic [15:0] BASE   = 16'hE000
) (
  input  logic                      pixclk,
  input  logic                      rst,
  input  logic [15:0]               ADD,
  input  logic                      RD,
  input  logic                      MREQ,
  input  logic [$clog2(CELL_W)-1:0] phase,
  input  logic [10:0]               vid_addr,
  output logic [10:0]               ram_addr,
  output logic                      ram_clk,
  input  logic [7:0]                vr_q,
  input  logic [7:0]                ar_q,
  output logic [7:0]                vid_chr,
  output logic [7:0]                vid_atr,
  output logic [7:0]                DOUT,
  output logic                      DOE,
  output logic                      READY
);
  localparam int          PW = $clog2(CELL_W);
  localparam logic [16:0] LO = {1'b0, BASE};
  localparam logic [16:0] HI = LO + 17'd4096;

  typedef enum logic [1:0] {IDLE, PEND, FETCH, DONE} state_t;

  state_t      state;
  logic [1:0]  rd_sync, mreq_sync;
  logic        rd_s, mreq_s, in_win, raw_req, req_s;
  logic [11:0] off;
  logic [10:0] cpu_addr, ram_addr_q;
  logic        sel, vid_slot, cpu_slot, vid_clk, cpu_clk;

  assign in_win   = ({1'b0, ADD} >= LO) && ({1'b0, ADD} < HI);
  assign off      = ADD[11:0] - BASE[11:0];
  assign raw_req  = !MREQ && !RD && in_win;
  assign rd_s     = rd_sync[1];
  assign mreq_s   = mreq_sync[1];
  assign req_s    = !rd_s && !mreq_s && in_win;
  assign vid_slot = phase <= PW'(5);
  assign cpu_slot = state == FETCH && phase >= PW'(8) && phase <= PW'(13);
  assign vid_clk  = phase == PW'(2) || phase == PW'(3);
  assign cpu_clk  = state == FETCH && (phase == PW'(10) || phase == PW'(11));
  assign ram_clk  = rst && (vid_clk || cpu_clk);
  // Wait is combinational so the CPU stalls in the same cycle it asserts the read.
  assign READY    = !rst || !raw_req || state == DONE;

  // Display slot wins phases 0-5, CPU slot phases 8-13 while fetching, otherwise the address is held.
  always_comb
    ram_addr = !rst ? 11'd0 : vid_slot ? vid_addr : cpu_slot ? cpu_addr : ram_addr_q;

  // Two-flop synchronizers for the asynchronous CPU strobes, plus the held RAM address.
  always_ff @(posedge pixclk or negedge rst)
    if (!rst) begin
      rd_sync    <= 2'b11;
      mreq_sync  <= 2'b11;
      ram_addr_q <= 11'd0;
    end else begin
      rd_sync    <= {rd_sync[0], RD};
      mreq_sync  <= {mreq_sync[0], MREQ};
      ram_addr_q <= ram_addr;
    end

  // Display bytes are captured at the end of phase 6, independent of CPU traffic.
  always_ff @(posedge pixclk or negedge rst)
    if (!rst) begin
      vid_chr <= 8'h00;
      vid_atr <= 8'h00;
    end else if (phase == PW'(6)) begin
      vid_chr <= vr_q;
      vid_atr <= ar_q;
    end

  // CPU read sequencer: latch request, wait for the CPU slot, deliver the byte, hold until RD rises.
  always_ff @(posedge pixclk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cpu_addr <= 11'd0;
      sel      <= 1'b0;
      DOUT     <= 8'h00;
      DOE      <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_s) begin
            cpu_addr <= off[10:0];
            sel      <= off[11];
            state    <= PEND;
          end
        PEND:
          if (rd_s || mreq_s) state <= IDLE;
          else if (phase == PW'(8)) state <= FETCH;
        FETCH:
          if (rd_s || mreq_s) state <= IDLE;
          else if (phase == PW'(14)) begin
            DOUT  <= sel ? vr_q : ar_q;
            DOE   <= 1'b1;
            state <= DONE;
          end
        DONE:
          if (rd_s) begin
            DOE   <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
